// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide on magnitudes.
// Optional MULDIV_EARLY_OUT_EN: skip CALC for divide-by-zero, signed overflow and zero-operand multiplies.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state, state_n;
  logic [5:0]        cnt;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r, b_r;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic              neg_r, divz_r, ovf_r;
  logic              accept;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  // One shift-add step: conditionally add multiplicand into the high half, then shift right.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0] m);
    logic [XLEN:0] sum;
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    return {sum, p[XLEN-1:1]};
  endfunction

  // One restoring step on {rem,quot}: shift left, trial subtract, keep if non-negative.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0]   rs;
    logic [XLEN+1:0] diff;
    rs   = p[2*XLEN-1:XLEN-1];
    diff = {1'b0, rs} - {2'b00, d};
    if (!diff[XLEN+1]) return {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else               return {rs[XLEN-1:0], p[XLEN-2:0], 1'b0};
  endfunction

  logic            is_div, sgn_a, sgn_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            sign_n, divz_n, ovf_n, early;

  always_comb begin
    is_div = op_r[2];
    sgn_a  = (op_r == 3'b001) || (op_r == 3'b010) || (op_r == 3'b100) || (op_r == 3'b110);
    sgn_b  = (op_r == 3'b001) || (op_r == 3'b100) || (op_r == 3'b110);
    sa     = sgn_a & a_r[XLEN-1];
    sb     = sgn_b & b_r[XLEN-1];
    mag_a  = sa ? neg_w(a_r) : a_r;
    mag_b  = sb ? neg_w(b_r) : b_r;
    // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
    sign_n = (is_div && op_r[1]) ? sa : (sa ^ sb);
    divz_n = (b_r == '0);
    ovf_n  = is_div && !op_r[0] && (a_r == MIN_NEG) && (b_r == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early  = is_div ? (divz_n || ovf_n) : ((a_r == '0) || divz_n);
`else
    early  = 1'b0;
`endif
  end

  assign accept = start && !flush && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done   = (state == S_DONE);

  always_comb begin
    state_n = state;
    if (flush) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (start) state_n = S_PREP;
        S_PREP:  state_n = early ? S_FIX : S_CALC;
        S_CALC:  if (cnt == 6'd0) state_n = S_FIX;
        S_FIX:   state_n = S_DONE;
        S_DONE:  state_n = start ? S_PREP : S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_val;
`ifdef MULDIV_EARLY_OUT_EN
  logic              mzero_r;
`endif

  always_comb begin
    prod = neg_r ? neg_dw(acc) : acc;
    quot = neg_r ? neg_w(acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_r ? neg_w(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    case (op_r)
      3'b000:                 fix_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = divz_r ? '1 : (ovf_r ? MIN_NEG : quot);
      default:                fix_val = divz_r ? a_r : (ovf_r ? '0 : rem);
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!op_r[2] && mzero_r) fix_val = '0;
`endif
  end

  // Control: state, iteration counter and the architecturally visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      result <= '0;
    end else begin
      state <= state_n;
      if (state == S_PREP) cnt <= 6'(ITERS - 1);
      else if (state == S_CALC && cnt != 6'd0) cnt <= cnt - 6'd1;
      if (state == S_FIX && !flush) result <= fix_val;
    end
  end

  // Datapath: operand capture, magnitude preparation and iteration register.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
    end
    if (state == S_PREP) begin
      acc    <= {{XLEN{1'b0}}, mag_a};
      mcand  <= mag_b;
      neg_r  <= sign_n;
      divz_r <= divz_n;
      ovf_r  <= ovf_n;
`ifdef MULDIV_EARLY_OUT_EN
      mzero_r <= (a_r == '0) || divz_n;
`endif
    end else if (state == S_CALC) begin
      acc <= op_r[2] ? div_step(acc, mcand) : mul_step(acc, mcand);
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected result and latency queued at accept, checked on done.
`timescale 1ns/1ps
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
  } exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] last_exp = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    logic signed [31:0] qx, qy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    qx = x;
    qy = y;
    case (o)
      3'b000: begin p = sx * sy; return p[31:0];  end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(qx / qy);
      end
      3'b101: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(qx % qy);
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_for(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[2] && y == 32'd0) return 2;
    if (!o[0] && o[2] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    if (!o[2] && (x == 32'd0 || y == 32'd0)) return 2;
`endif
    return 34;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) check_eq("spurious_done", 32'(done), 32'd0);
      else begin
        mon_e = sbq.pop_front();
        check_eq("result", result, mon_e.res);
        check_eq("latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
      end
    end
  end

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input bit push);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    if (push) begin
      e.res = expv; e.acc_cyc = cyc; e.lat = lat_for(o, x, y);
      sbq.push_back(e);
      last_exp = expv;
    end
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (sbq.size() != 0) begin
      check_eq("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expv);
    @(negedge clk);
    launch(o, x, y, expv, 1'b1);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op(3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    do_op(3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    do_op(3'b111, 32'h1234, 32'd0, 32'h1234);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    do_op(3'b000, 32'd0, 32'd5, 32'd0);
    do_op(3'b001, 32'h1234_5678, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'($urandom_range(1, 17));
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(ro, rx, ry, model(ro, rx, ry));
    end

    // start while busy must be ignored
    @(negedge clk);
    launch(3'b100, 32'd100, 32'd7, 32'd14, 1'b1);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_ignore_start", 32'(busy), 32'd1);
    wait_drain();
    repeat (40) @(posedge clk);

    // flush mid-divide
    @(negedge clk);
    launch(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_done", 32'(done), 32'd0);
    repeat (40) @(posedge clk); #1;
    check_eq("flush_result_kept", result, last_exp);

    // back-to-back: second op accepted in the DONE cycle
    @(negedge clk);
    launch(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    if (!done) check_eq("b2b_done_seen", 32'(done), 32'd1);
    launch(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    repeat (10) @(posedge clk); #1;
    check_eq("b2b_result_held", result, 32'hFFFF_FFEB);
    wait_drain();

    // reset mid-CALC together with start
    @(negedge clk);
    launch(3'b101, 32'd99, 32'd7, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_done", 32'(done), 32'd0);
    check_eq("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
